phaser_array: RTL and testbench

- Parametrised multi-channel phase generator, next generation of the single-pair triangle-counter phaser.
- One shared WIDTH-bit up/down (triangle) or up-only (sawtooth) carrier counter drives CHANNELS compare channels. Each channel toggles its output when the counter crosses its compare value.
- Adds shadowed compare registers loaded through a write port and applied glitch-free at period start, plus per-channel enable, per-channel polarity and a period-start strobe.
- Sits between the control register file and the phase-array output drivers.

---
 rtl/phaser_array.sv | 135 +++++++++++++
 tb/tb_phaser_array.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phaser_array.sv
// phaser_array: multi-channel phase generator built around one shared carrier.
// A WIDTH-bit counter runs as a triangle (up/down) or a sawtooth (up only).
// Each of CHANNELS compare channels toggles its output the first cycle the
// carrier equals its compare value. Compare values are written into shadow
// registers and copied into the active set only at the period boundary, so a
// write can never cut a period short.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   mode     0 = triangle, 1 = sawtooth (taken at the period boundary)
//   wr_en    shadow compare write strobe
//   wr_addr  channel index for the write (out-of-range indices are dropped)
//   wr_data  compare value to write
//   en       per-channel enable
//   pol      per-channel output inversion
//   out      registered channel outputs
//   count    current carrier value
//   dir      carrier direction, 0 = up, 1 = down
//   pstart   high during every period-boundary cycle (combinational)
module phaser_array #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] pol,
  output logic [CHANNELS-1:0] out,
  output logic [WIDTH-1:0]    count,
  output logic                dir,
  output logic                pstart
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0]                count_q, count_d;
  logic                            dir_q, dir_d;
  logic                            mode_q, mode_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  shadow_q, shadow_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  cmp_q, cmp_d;
  logic [CHANNELS-1:0]             tog_q, tog_d;
  logic [CHANNELS-1:0]             match_q, match_d;
  logic [CHANNELS-1:0]             out_q, out_d;
  logic                            bnd_c;

  // Period boundary: carrier at zero at the bottom of a triangle, or any
  // zero in sawtooth mode.
  assign bnd_c = (count_q == '0) && (mode_q || dir_q);

  // Carrier counter, mode sampling and compare transfer.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    cmp_d   = cmp_q;
    if (bnd_c) begin
      mode_d  = mode;
      dir_d   = 1'b0;
      cmp_d   = shadow_q;
      // Sawtooth skips the second zero cycle so its period is 2^WIDTH.
      count_d = mode ? WIDTH'(1) : '0;
    end else if (mode_q) begin
      dir_d   = 1'b0;
      count_d = count_q + WIDTH'(1);
    end else if (!dir_q && (count_q == MAX)) begin
      dir_d = 1'b1;  // dwell one extra cycle at the top
    end else if (dir_q) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Shadow compare write port; a write in the boundary cycle lands after the
  // transfer and waits for the next boundary.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && (32'(wr_addr) < CHANNELS)) begin
      shadow_d[wr_addr] = wr_data;
    end
  end

  // Per-channel first-cycle match detection, toggle state and output.
  always_comb begin
    match_d = '0;
    tog_d   = '0;
    out_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      match_d[i] = (count_q == cmp_q[i]);
      if (!en[i]) begin
        tog_d[i] = 1'b0;
      end else if (match_d[i] && !match_q[i]) begin
        tog_d[i] = ~tog_q[i];
      end else begin
        tog_d[i] = tog_q[i];
      end
      out_d[i] = en[i] ? (tog_d[i] ^ pol[i]) : pol[i];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      dir_q    <= 1'b1;
      mode_q   <= 1'b0;
      shadow_q <= '0;
      cmp_q    <= '0;
      tog_q    <= '0;
      match_q  <= '0;
      out_q    <= '0;
    end else begin
      count_q  <= count_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      cmp_q    <= cmp_d;
      tog_q    <= tog_d;
      match_q  <= match_d;
      out_q    <= out_d;
    end
  end

  assign out    = out_q;
  assign count  = count_q;
  assign dir    = dir_q;
  assign pstart = bnd_c;

endmodule

// File: tb/tb_phaser_array.sv
// Self-checking bench for phaser_array (WIDTH=4, CHANNELS=2). The reference
// model tracks the position inside the current period and derives count,
// direction and boundary from that position with plain arithmetic.
module tb_phaser_array;

  localparam int unsigned W    = 4;
  localparam int unsigned CH   = 2;
  localparam int unsigned AW   = 1;
  localparam int unsigned MAXV = (1 << W) - 1;
  localparam int unsigned VW   = W + 2 + CH;

  logic          clk;
  logic          rst;
  logic          mode;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] en;
  logic [CH-1:0] pol;
  logic [CH-1:0] out;
  logic [W-1:0]  count;
  logic          dir;
  logic          pstart;
  logic [VW-1:0] obs;

  phaser_array #(.WIDTH(W), .CHANNELS(CH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .en(en), .pol(pol), .out(out), .count(count),
    .dir(dir), .pstart(pstart)
  );

  assign obs = {count, dir, pstart, out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state.
  int unsigned   m_pos;
  bit            m_mq;
  int unsigned   m_cmp[CH];
  int unsigned   m_sh[CH];
  logic [CH-1:0] m_tog;
  logic [CH-1:0] m_pm;
  logic [CH-1:0] m_out;

  function automatic int unsigned m_count();
    if (m_mq) return m_pos;
    if (m_pos == 0) return 0;
    if (m_pos <= MAXV + 1) return m_pos - 1;
    return 2 * MAXV + 2 - m_pos;
  endfunction

  function automatic bit m_dir();
    if (m_mq) return 1'b0;
    return (m_pos == 0) || (m_pos > MAXV + 1);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {W'(m_count()), m_dir(), (m_pos == 0), m_out};
  endfunction

  task automatic m_reset();
    m_pos = 0; m_mq = 1'b0; m_tog = '0; m_pm = '0; m_out = '0; cyc = 0;
    for (int i = 0; i < CH; i++) begin m_cmp[i] = 0; m_sh[i] = 0; end
  endtask

  // Advance one clock: model next state from current inputs, then the edge.
  task automatic step();
    int unsigned   c;
    int unsigned   n_cmp[CH];
    int unsigned   n_sh[CH];
    logic [CH-1:0] n_tog, n_pm, n_out;
    int unsigned   n_pos;
    bit            n_mq;
    bit            hit;
    c = m_count();
    for (int i = 0; i < CH; i++) begin
      hit      = (c == m_cmp[i]);
      n_pm[i]  = hit;
      n_tog[i] = en[i] ? (m_tog[i] ^ (hit && !m_pm[i])) : 1'b0;
      n_out[i] = en[i] ? (n_tog[i] ^ pol[i]) : pol[i];
      n_cmp[i] = m_cmp[i];
      n_sh[i]  = m_sh[i];
    end
    if (m_pos == 0) begin
      n_mq  = mode;
      n_pos = 1;
      for (int i = 0; i < CH; i++) n_cmp[i] = m_sh[i];
    end else begin
      n_mq  = m_mq;
      n_pos = (m_pos == (m_mq ? MAXV : 2 * MAXV + 1)) ? 0 : m_pos + 1;
    end
    if (wr_en && (int'(wr_addr) < int'(CH))) n_sh[wr_addr] = int'(wr_data);
    @(posedge clk);
    #1;
    m_pos = n_pos; m_mq = n_mq; m_tog = n_tog; m_pm = n_pm; m_out = n_out;
    for (int i = 0; i < CH; i++) begin m_cmp[i] = n_cmp[i]; m_sh[i] = n_sh[i]; end
    cyc++;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({count, dir, out} !== {W'(0), 1'b1, CH'(0)}) begin
      n_fail++; $display("FAIL reset_hold got=%h exp=%h", {count, dir, out}, {W'(0), 1'b1, CH'(0)});
    end
    rst = 1'b1;
    m_reset();
    n_checks++;
    if (pstart !== 1'b1) begin n_fail++; $display("FAIL reset_first_b got=%b exp=1", pstart); end
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_cyc0 got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_triangle();
    while (cyc < 27) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL tri cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (cyc == 16 || cyc == 17) begin
        n_checks++;
        if (count !== W'(15)) begin n_fail++; $display("FAIL tri_top cyc=%0d got=%0d exp=15", cyc, count); end
      end
      n_checks++;
      if (out !== 2'b00) begin n_fail++; $display("FAIL tri_out cyc=%0d got=%b exp=00", cyc, out); end
    end
  endtask

  task automatic test_duty();
    int rise = -1;
    int fall = -1;
    wr_en = 1'b1; wr_addr = 1'b0; wr_data = W'(5); step();
    wr_addr = 1'b1; wr_data = W'(15); step();
    wr_en = 1'b0;
    while (cyc < 33) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL duty_pre cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (cyc == 32) begin
        n_checks++;
        if (pstart !== 1'b1) begin n_fail++; $display("FAIL duty_b32 got=%b exp=1", pstart); end
      end
    end
    en = 2'b11;
    while (cyc < 100) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL duty cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (rise < 0 && out[0] === 1'b1) rise = cyc;
      if (rise >= 0 && fall < 0 && out[0] === 1'b0) fall = cyc;
      if (cyc == 49) begin
        n_checks++;
        if (out[1] !== 1'b1) begin n_fail++; $display("FAIL duty_ch1 got=%b exp=1", out[1]); end
      end
    end
    n_checks++;
    if (rise != 39 || fall != 60) begin
      n_fail++; $display("FAIL duty_edges rise=%0d fall=%0d exp rise=39 fall=60", rise, fall);
    end
  endtask

  task automatic test_pol_en();
    pol = 2'b10; step();
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL pol cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    en = 2'b01;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (out[1] !== 1'b1) begin n_fail++; $display("FAIL en_off cyc=%0d got=%b exp=1", cyc, out[1]); end
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL en_off_m cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    en = 2'b11; pol = 2'b00;
  endtask

  task automatic test_b_write();
    bit   found = 1'b0;
    int   off;
    int   first1 = -1;
    int   first2 = -1;
    logic prev;
    for (int k = 0; k < 70 && !found; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL bw_wait cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (pstart === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL bw_timeout got=no_boundary exp=boundary"); end
    wr_en = 1'b1; wr_addr = 1'b0; wr_data = W'(9); step(); wr_en = 1'b0;
    off  = 1;
    prev = out[0];
    for (int k = 0; k < 64; k++) begin
      step();
      off++;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL bw cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (out[0] !== prev) begin
        if (off < 32 && first1 < 0) first1 = off;
        if (off >= 32 && first2 < 0) first2 = off - 32;
      end
      prev = out[0];
    end
    n_checks++;
    if (first1 != 7 || first2 != 11) begin
      n_fail++; $display("FAIL bw_edges got=%0d,%0d exp=7,11", first1, first2);
    end
  endtask

  task automatic test_sawtooth();
    int p_prev = -1;
    int p_last = -1;
    mode = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL saw cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (pstart === 1'b1) begin p_prev = p_last; p_last = cyc; end
    end
    n_checks++;
    if (p_prev < 0 || (p_last - p_prev) != 16) begin
      n_fail++; $display("FAIL saw_period got=%0d exp=16", p_last - p_prev);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, CH - 1));
      wr_data = W'($urandom);
      if ($urandom_range(0, 9) == 0) en = CH'($urandom);
      if ($urandom_range(0, 9) == 0) pol = CH'($urandom);
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      step();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL rand cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    wr_en = 1'b0; mode = 1'b0; en = 2'b11; pol = 2'b00;
  endtask

  task automatic test_async_reset();
    step();
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({count, dir, out} !== {W'(0), 1'b1, CH'(0)}) begin
      n_fail++; $display("FAIL async_clear got=%h exp=%h", {count, dir, out}, {W'(0), 1'b1, CH'(0)});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    m_reset();
    n_checks++;
    if (obs !== exp_vec() || pstart !== 1'b1) begin
      n_fail++; $display("FAIL async_restart got=%h exp=%h", obs, exp_vec());
    end
    for (int k = 0; k < 40; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (cyc == 1) begin
        n_checks++;
        if (out !== 2'b11) begin n_fail++; $display("FAIL restart_cmp0 got=%b exp=11", out); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mode = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    en = '0; pol = '0;
    m_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_triangle();
    test_duty();
    test_pol_en();
    test_b_write();
    test_sawtooth();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
